traffic_monitor: RTL

//  Passive receiver/checker for the 6-lamp bus driven by the 2-way traffic light controller.

---
 rtl/traffic_monitor.sv | 183 ++++++++++++++++++
 1 files changed

// File: rtl/traffic_monitor.sv
// Passive checker for the 6-lamp bus of a 2-way traffic light controller: decodes phase, times runs, flags errors.
// Optional TRAFFIC_MON_COUNT_EN adds a saturating err_count output.
module traffic_monitor #(
  parameter int GREEN_CYC  = 15,
  parameter int YELLOW_CYC = 3,
  parameter int ALLRED_CYC = 3,
  parameter int CNT_W      = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       clr,
  input  logic       R1,
  input  logic       Y1,
  input  logic       G1,
  input  logic       R2,
  input  logic       Y2,
  input  logic       G2,
  output logic [2:0] phase,
  output logic       locked,
  output logic [3:0] err_flags,
  output logic       err_pulse
`ifdef TRAFFIC_MON_COUNT_EN
  ,
  output logic [7:0] err_count
`endif
);

  localparam logic [CNT_W-1:0] GREEN_L  = CNT_W'(GREEN_CYC);
  localparam logic [CNT_W-1:0] YELLOW_L = CNT_W'(YELLOW_CYC);
  localparam logic [CNT_W-1:0] ALLRED_L = CNT_W'(ALLRED_CYC);
  localparam logic [CNT_W-1:0] ONE_L    = CNT_W'(1);

  typedef enum logic [2:0] {
    PAT_NSG,
    PAT_NSY,
    PAT_ALLR,
    PAT_EWG,
    PAT_EWY,
    PAT_BAD
  } pat_e;

  logic [5:0]       lamp_d;
  logic [5:0]       lamp_q;
  logic             primed;
  logic             tracked;
  logic [CNT_W-1:0] run_len;

  pat_e             cur_pat;
  pat_e             prev_pat;
  logic             changed;
  logic [2:0]       succ_ph;
  logic [CNT_W-1:0] dur_cur;
  logic [3:0]       err_vec;
  logic             step_ok;
  logic [2:0]       step_ph;
  logic             any_err;

  function automatic pat_e decode(input logic [5:0] l);
    case (l)
      6'b001_100: decode = PAT_NSG;
      6'b010_100: decode = PAT_NSY;
      6'b100_100: decode = PAT_ALLR;
      6'b100_001: decode = PAT_EWG;
      6'b100_010: decode = PAT_EWY;
      default:    decode = PAT_BAD;
    endcase
  endfunction

  function automatic pat_e phase_pat(input logic [2:0] ph);
    case (ph)
      3'd0:    phase_pat = PAT_NSG;
      3'd1:    phase_pat = PAT_NSY;
      3'd3:    phase_pat = PAT_EWG;
      3'd4:    phase_pat = PAT_EWY;
      default: phase_pat = PAT_ALLR;
    endcase
  endfunction

  function automatic logic [CNT_W-1:0] dur_of(input logic [2:0] ph);
    case (ph)
      3'd0, 3'd3: dur_of = GREEN_L;
      3'd1, 3'd4: dur_of = YELLOW_L;
      default:    dur_of = ALLRED_L;
    endcase
  endfunction

  assign lamp_d   = {R1, Y1, G1, R2, Y2, G2};
  assign cur_pat  = decode(lamp_d);
  assign prev_pat = decode(lamp_q);
  assign changed  = (lamp_d != lamp_q);
  assign succ_ph  = (phase == 3'd5) ? 3'd0 : phase + 3'd1;
  assign dur_cur  = dur_of(phase);
  assign any_err  = |err_vec;

  // Sequence and timing are only judged on electrically sane patterns; a bad
  // pattern reports only its electrical fault(s).
  always_comb begin
    err_vec = 4'b0000;
    step_ok = 1'b0;
    step_ph = phase;
    if (primed) begin
      err_vec[0] = (Y1 | G1) & (Y2 | G2);
      err_vec[1] = !$onehot({R1, Y1, G1}) || !$onehot({R2, Y2, G2});
      if (cur_pat != PAT_BAD) begin
        if (locked) begin
          if (changed) begin
            if (cur_pat == phase_pat(succ_ph)) begin
              step_ok = 1'b1;
              step_ph = succ_ph;
            end else begin
              err_vec[2] = 1'b1;
            end
            if (tracked && run_len != dur_cur) err_vec[3] = 1'b1;
          end else if (tracked && run_len == dur_cur) begin
            err_vec[3] = 1'b1;
          end
        end else if (changed) begin
          // All-red is resolved by the yellow it was entered from, and by the green it exits to.
          if (prev_pat == PAT_NSG && cur_pat == PAT_NSY) begin
            step_ok = 1'b1;
            step_ph = 3'd1;
          end else if (prev_pat == PAT_NSY && cur_pat == PAT_ALLR) begin
            step_ok = 1'b1;
            step_ph = 3'd2;
          end else if (prev_pat == PAT_ALLR && cur_pat == PAT_EWG) begin
            step_ok = 1'b1;
            step_ph = 3'd3;
          end else if (prev_pat == PAT_EWG && cur_pat == PAT_EWY) begin
            step_ok = 1'b1;
            step_ph = 3'd4;
          end else if (prev_pat == PAT_EWY && cur_pat == PAT_ALLR) begin
            step_ok = 1'b1;
            step_ph = 3'd5;
          end else if (prev_pat == PAT_ALLR && cur_pat == PAT_NSG) begin
            step_ok = 1'b1;
            step_ph = 3'd0;
          end
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lamp_q    <= 6'b000000;
      primed    <= 1'b0;
      run_len   <= '0;
      tracked   <= 1'b0;
      locked    <= 1'b0;
      phase     <= 3'd0;
      err_flags <= 4'b0000;
      err_pulse <= 1'b0;
    end else begin
      lamp_q    <= lamp_d;
      primed    <= 1'b1;
      if (!primed || changed) run_len <= ONE_L;
      else if (run_len != '1) run_len <= run_len + ONE_L;
      err_pulse <= any_err;
      err_flags <= clr ? err_vec : (err_flags | err_vec);
      if (any_err) begin
        locked  <= 1'b0;
        tracked <= 1'b0;
      end else if (step_ok) begin
        locked  <= 1'b1;
        tracked <= 1'b1;
        phase   <= step_ph;
      end
    end
  end

`ifdef TRAFFIC_MON_COUNT_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_count <= 8'd0;
    end else if (clr) begin
      err_count <= {7'd0, any_err};
    end else if (any_err && err_count != 8'hff) begin
      err_count <= err_count + 8'd1;
    end
  end
`endif

endmodule
